// File: rtl/vec_rf_wb_queue_if.sv
// Bundle of the write-back, operand-read and regfile-port signals around
// vec_rf_wb_queue. The slave modport is the queue itself; the master modport
// is everything around it (ALU write-back, operand fetch and vec_regfile).
interface vec_rf_wb_queue_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 5
);
  logic                  wb_valid;
  logic                  wb_ready;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_resp_valid;
  logic [DATA_WIDTH-1:0] rd_resp_data;
  logic                  rf_en;
  logic                  rf_rw;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_data_in;
  logic [DATA_WIDTH-1:0] rf_data_out;

  modport master (
    output wb_valid, wb_addr, wb_data, rd_valid, rd_addr, rf_data_out,
    input  wb_ready, rd_ready, rd_resp_valid, rd_resp_data,
    input  rf_en, rf_rw, rf_addr, rf_data_in
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, rd_valid, rd_addr, rf_data_out,
    output wb_ready, rd_ready, rd_resp_valid, rd_resp_data,
    output rf_en, rf_rw, rf_addr, rf_data_in
  );
endinterface

// File: rtl/vec_rf_wb_queue.sv
// Write-back queue and access arbiter in front of the single-port vector
// register file. ALU write-backs are buffered in a circular FIFO; operand
// reads compete with the queue head for the one regfile op per cycle.
// A read that hits a queued write is either stalled until the queue has
// drained past it (default build) or served from the youngest matching
// entry when the macro VEC_WBQ_FWD_EN is defined.
module vec_rf_wb_queue #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input logic              clk,
  input logic              rst_n,
  vec_rf_wb_queue_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Queue storage (data path only, no reset needed: validity comes from count)
  logic [ADDR_WIDTH-1:0] q_addr_r [DEPTH];
  logic [DATA_WIDTH-1:0] q_data_r [DEPTH];

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic rd_resp_valid_r;

  logic full_s;
  logic empty_s;
  logic hit_s;
  logic rd_ready_s;
  logic rd_fire_s;
  logic fwd_s;
  logic rd_to_rf_s;
  logic drain_s;
  logic push_s;

`ifdef VEC_WBQ_FWD_EN
  logic [DATA_WIDTH-1:0] hit_data_s;
  logic [DATA_WIDTH-1:0] fwd_data_r;
  logic                  fwd_sel_r;
`endif

  assign full_s  = (count_r == FULL_CNT);
  assign empty_s = (count_r == {CNT_W{1'b0}});

  // Scan valid entries head-to-tail; the last match seen is the youngest
  always_comb begin
    logic [PTR_W-1:0] slot_s;
    logic             m_s;
    hit_s  = 1'b0;
    slot_s = {PTR_W{1'b0}};
    m_s    = 1'b0;
`ifdef VEC_WBQ_FWD_EN
    hit_data_s = {DATA_WIDTH{1'b0}};
`endif
    for (int i = 0; i < DEPTH; i++) begin
      slot_s = rd_ptr_r + PTR_W'(i);
      m_s    = (CNT_W'(i) < count_r) && (q_addr_r[slot_s] == bus.rd_addr);
      hit_s  = hit_s | m_s;
`ifdef VEC_WBQ_FWD_EN
      hit_data_s = m_s ? q_data_r[slot_s] : hit_data_s;
`endif
    end
  end

  // Arbitration: full queue forces a drain, else an accepted read wins the
  // port unless it is forwarded, else a non-empty queue drains its head
  always_comb begin
`ifdef VEC_WBQ_FWD_EN
    rd_ready_s = !full_s;
`else
    rd_ready_s = !full_s && !hit_s;
`endif
    rd_fire_s = bus.rd_valid && rd_ready_s;
`ifdef VEC_WBQ_FWD_EN
    fwd_s = rd_fire_s && hit_s;
`else
    fwd_s = 1'b0;
`endif
    rd_to_rf_s = rd_fire_s && !fwd_s;
    drain_s    = !empty_s && !rd_to_rf_s;
    push_s     = bus.wb_valid && !full_s;
  end

  // Regfile port drive; enable is held off while reset is asserted
  always_comb begin
    bus.rf_en = rst_n && (rd_to_rf_s || drain_s);
    if (drain_s) begin
      bus.rf_rw      = 1'b1;
      bus.rf_addr    = q_addr_r[rd_ptr_r];
      bus.rf_data_in = q_data_r[rd_ptr_r];
    end else begin
      bus.rf_rw      = 1'b0;
      bus.rf_addr    = bus.rd_addr;
      bus.rf_data_in = {DATA_WIDTH{1'b0}};
    end
  end

  assign bus.wb_ready      = !full_s;
  assign bus.rd_ready      = rd_ready_s;
  assign bus.rd_resp_valid = rd_resp_valid_r;

  // FIFO pointers and occupancy; push is already blocked when full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (drain_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, drain_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue entry write on push
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_addr_r[wr_ptr_r] <= bus.wb_addr;
      q_data_r[wr_ptr_r] <= bus.wb_data;
    end else begin
      q_addr_r[wr_ptr_r] <= q_addr_r[wr_ptr_r];
      q_data_r[wr_ptr_r] <= q_data_r[wr_ptr_r];
    end
  end

  // Response valid follows read acceptance by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_resp_valid_r <= 1'b0;
    end else begin
      rd_resp_valid_r <= rd_fire_s;
    end
  end

`ifdef VEC_WBQ_FWD_EN
  // Capture forwarded data in the accept cycle so later queue changes cannot alter it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_sel_r  <= 1'b0;
      fwd_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      fwd_sel_r <= fwd_s;
      if (fwd_s) begin
        fwd_data_r <= hit_data_s;
      end else begin
        fwd_data_r <= fwd_data_r;
      end
    end
  end

  // Response data: forwarded entry or regfile output, zero when idle
  always_comb begin
    if (!rd_resp_valid_r) begin
      bus.rd_resp_data = {DATA_WIDTH{1'b0}};
    end else if (fwd_sel_r) begin
      bus.rd_resp_data = fwd_data_r;
    end else begin
      bus.rd_resp_data = bus.rf_data_out;
    end
  end
`else
  // Response data: regfile output, zero when idle
  always_comb begin
    if (rd_resp_valid_r) begin
      bus.rd_resp_data = bus.rf_data_out;
    end else begin
      bus.rd_resp_data = {DATA_WIDTH{1'b0}};
    end
  end
`endif

endmodule
